// File: rtl/seg7_decode_monitor_if.sv
// Segment-bus loopback interface: the driver side presents the raw segment bus
// and a soft clear; the monitor side returns decoded digits and error status.
interface seg7_decode_monitor_if;
  logic [6:0] seg_in;
  logic       clear;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       seq_err;
  logic       bad_pattern;
  logic       timeout;
  logic [7:0] err_count;

  modport master (
    output seg_in, clear,
    input  digit_out, digit_valid, seq_err, bad_pattern, timeout, err_count
  );

  modport slave (
    input  seg_in, clear,
    output digit_out, digit_valid, seq_err, bad_pattern, timeout, err_count
  );
endinterface

// File: rtl/seg7_decode_monitor.sv
// Receive-side 7-segment checker: synchronise, debounce, decode to hex, and
// verify that accepted digits count up by one, flagging stalls and bad patterns.
module seg7_decode_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 30_000_000,
  parameter int TMO_W          = 25
) (
  input logic                  clk,
  input logic                  rst_n,
  seg7_decode_monitor_if.slave bus
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    TRACK      = 2'd1,
    TIMED_OUT  = 2'd2
  } state_t;

  logic [6:0]       sync1_q, sync2_q;
  logic [6:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       acc_q;
  state_t           state_q;
  logic [3:0]       digit_q;
  logic             dv_q, se_q, bp_q, timeout_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       err_q;

  logic             accept_d;
  logic             blank_d;
  logic             dec_ok_d;
  logic [3:0]       dec_val_d;
  logic [TMO_W-1:0] tmo_d;

  // Returns {valid, hex value}; blank (00) is reported as not valid here.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F: seg_decode = 5'h10;
      7'h06: seg_decode = 5'h11;
      7'h5B: seg_decode = 5'h12;
      7'h4F: seg_decode = 5'h13;
      7'h66: seg_decode = 5'h14;
      7'h6D: seg_decode = 5'h15;
      7'h7D: seg_decode = 5'h16;
      7'h07: seg_decode = 5'h17;
      7'h7F: seg_decode = 5'h18;
      7'h6F: seg_decode = 5'h19;
      7'h77: seg_decode = 5'h1A;
      7'h7C: seg_decode = 5'h1B;
      7'h39: seg_decode = 5'h1C;
      7'h5E: seg_decode = 5'h1D;
      7'h79: seg_decode = 5'h1E;
      7'h71: seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    sat_inc = (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  always_comb begin
    accept_d  = (cnt_q == CNT_MAX) && (cand_q != acc_q);
    blank_d   = (cand_q == 7'h00);
    {dec_ok_d, dec_val_d} = seg_decode(cand_q);
    tmo_d     = tmo_q + TMO_W'(1);
  end

  // Synchroniser and stability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 7'h00;
      sync2_q <= 7'h00;
      cand_q  <= 7'h00;
      cnt_q   <= '0;
    end else begin
      sync1_q <= bus.seg_in;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Accept handling, sequence check and stall detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_FIRST;
      acc_q     <= 7'h00;
      digit_q   <= 4'h0;
      dv_q      <= 1'b0;
      se_q      <= 1'b0;
      bp_q      <= 1'b0;
      timeout_q <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 8'h00;
    end else begin
      dv_q <= 1'b0;
      se_q <= 1'b0;
      bp_q <= 1'b0;
      if (bus.clear) begin
        err_q     <= 8'h00;
        timeout_q <= 1'b0;
        state_q   <= WAIT_FIRST;
        acc_q     <= 7'h00;
        tmo_q     <= '0;
      end else if (accept_d) begin
        acc_q <= cand_q;
        tmo_q <= '0;
        if (blank_d) begin
          state_q   <= WAIT_FIRST;
          timeout_q <= 1'b0;
        end else if (dec_ok_d) begin
          digit_q   <= dec_val_d;
          dv_q      <= 1'b1;
          state_q   <= TRACK;
          timeout_q <= 1'b0;
          if ((state_q == TRACK) && (dec_val_d != 4'(digit_q + 4'd1))) begin
            se_q  <= 1'b1;
            err_q <= sat_inc(err_q);
          end
        end else begin
          // Invalid pattern: leave digit, state and expected value untouched.
          bp_q  <= 1'b1;
          err_q <= sat_inc(err_q);
        end
      end else if (state_q == TRACK) begin
        tmo_q <= tmo_d;
        if (tmo_d == TMO_LIMIT) begin
          timeout_q <= 1'b1;
          state_q   <= TIMED_OUT;
        end
      end
    end
  end

  assign bus.digit_out   = digit_q;
  assign bus.digit_valid = dv_q;
  assign bus.seq_err     = se_q;
  assign bus.bad_pattern = bp_q;
  assign bus.timeout     = timeout_q;
  assign bus.err_count   = err_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Directed bench for seg7_decode_monitor: stimulus queues expected events,
// a negedge monitor pops and compares each pulse the monitor produces.
module tb_seg7_decode_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_decode_monitor_if bus ();

  seg7_decode_monitor #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(100),
    .TMO_W         (25)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] d;
    logic       se;
    logic       bp;
    logic [7:0] err;
  } ev_t;

  ev_t q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic exp_ev(input logic [3:0] d, input logic se, input logic bp, input logic [7:0] e);
    ev_t ev;
    ev.d = d; ev.se = se; ev.bp = bp; ev.err = e;
    q.push_back(ev);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    bus.seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.digit_valid || bus.seq_err || bus.bad_pattern)) begin
      ev_t ev;
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: got dv=%0b se=%0b bp=%0b digit=%0h err=%0d with nothing expected",
                 bus.digit_valid, bus.seq_err, bus.bad_pattern, bus.digit_out, bus.err_count);
      end else begin
        ev = q.pop_front();
        if (bus.digit_valid === !ev.bp && bus.seq_err === ev.se && bus.bad_pattern === ev.bp &&
            bus.digit_out === ev.d && bus.err_count === ev.err)
          n_pass++;
        else
          $display("FAIL event: got dv=%0b se=%0b bp=%0b digit=%0h err=%0d expected dv=%0b se=%0b bp=%0b digit=%0h err=%0d",
                   bus.digit_valid, bus.seq_err, bus.bad_pattern, bus.digit_out, bus.err_count,
                   !ev.bp, ev.se, ev.bp, ev.d, ev.err);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.seg_in = 7'h00;
    bus.clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", 32'(bus.digit_out), 0);
    chk("rst_valid", 32'(bus.digit_valid), 0);
    chk("rst_err", 32'(bus.err_count), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First digit: pulse lands on the 7th edge after the change
    exp_ev(4'h0, 1'b0, 1'b0, 8'd0);
    bus.seg_in = 7'h3F;
    repeat (6) @(posedge clk);
    #1;
    chk("lat_early", 32'(bus.digit_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_edge7", 32'(bus.digit_valid), 1);
    hold(7'h3F, 13);

    exp_ev(4'h1, 1'b0, 1'b0, 8'd0); hold(7'h06, 20);
    exp_ev(4'h2, 1'b0, 1'b0, 8'd0); hold(7'h5B, 20);

    hold(7'h4F, 3);
    hold(7'h5B, 20);
    chk("glitch_digit", 32'(bus.digit_out), 2);

    exp_ev(4'h2, 1'b0, 1'b1, 8'd1); hold(7'h49, 10);
    exp_ev(4'h3, 1'b0, 1'b0, 8'd1); hold(7'h4F, 20);
    exp_ev(4'h8, 1'b1, 1'b0, 8'd2); hold(7'h7F, 20);

    hold(7'h00, 20);
    chk("blank_hold", 32'(bus.digit_out), 8);
    exp_ev(4'h1, 1'b0, 1'b0, 8'd2); hold(7'h06, 20);

    // Stall: accept of F then 100 TRACK cycles raise timeout
    exp_ev(4'hF, 1'b1, 1'b0, 8'd3); hold(7'h71, 60);
    chk("tmo_early", 32'(bus.timeout), 0);
    hold(7'h71, 55);
    chk("tmo_set", 32'(bus.timeout), 1);
    exp_ev(4'h4, 1'b0, 1'b0, 8'd3); hold(7'h66, 20);
    chk("tmo_clr", 32'(bus.timeout), 0);

    exp_ev(4'hF, 1'b1, 1'b0, 8'd4); hold(7'h71, 20);
    exp_ev(4'h0, 1'b0, 1'b0, 8'd4); hold(7'h3F, 20);

    for (int i = 0; i < 260; i++) begin
      exp_ev(4'h0, 1'b0, 1'b1, (5 + i > 255) ? 8'd255 : 8'(5 + i));
      hold((i % 2 == 1) ? 7'h12 : 7'h49, 8);
    end
    chk("sat_err", 32'(bus.err_count), 255);
    exp_ev(4'h1, 1'b0, 1'b0, 8'd255); hold(7'h06, 20);
    chk("sat_hold", 32'(bus.err_count), 255);

    // Clear: errors drop, current digit re-accepted one cycle later
    exp_ev(4'h1, 1'b0, 1'b0, 8'd0);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    chk("clr_err", 32'(bus.err_count), 0);
    chk("clr_timeout", 32'(bus.timeout), 0);
    chk("clr_digit", 32'(bus.digit_out), 1);
    chk("clr_noval", 32'(bus.digit_valid), 0);
    @(posedge clk);
    #1;
    chk("clr_reaccept", 32'(bus.digit_valid), 1);
    hold(7'h06, 18);

    // Asynchronous reset in the middle of filtering 5B
    bus.seg_in = 7'h5B;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_digit", 32'(bus.digit_out), 0);
    chk("arst_valid", 32'(bus.digit_valid), 0);
    chk("arst_err", 32'(bus.err_count), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ev(4'h2, 1'b0, 1'b0, 8'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("arst_nopulse", 32'(bus.digit_valid), 0);
    @(posedge clk);
    #1;
    chk("arst_pulse", 32'(bus.digit_valid), 1);
    hold(7'h5B, 20);

    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
